mem_wb_pipe_reg: RTL and testbench

- Parametrised, elastic successor to the fixed MEM/WB register.
- Carries NCH independent register-write channels (for example GPR plus HI/LO) from the MEM stage to the WB stage.
- Uses a valid/ready handshake with a 2-entry skid buffer, so WB-side back-pressure never needs a combinational ready path back to MEM.
- Supports synchronous flush, optional $zero write suppression and a saturating back-pressure counter for performance monitoring.

---
 rtl/mem_wb_pipe_reg.sv | 172 +++++++++++++++++
 tb/tb_mem_wb_pipe_reg.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_pipe_reg
// Purpose  : Elastic MEM/WB pipeline register carrying NCH register-write
//            channels. A 2-entry skid buffer (head + skid) lets the WB side
//            stall without a combinational ready path back to MEM.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous reset, active low
//            flush        - synchronous squash of all held entries
//            in_valid     - MEM stage presents an instruction
//            in_ready     - registered accept indication (~skid_v)
//            in_wr_en     - per-channel write enable
//            in_wr_addr   - channel i at [i*ADDR_W +: ADDR_W]
//            in_wr_data   - channel i at [i*DATA_W +: DATA_W]
//            out_valid    - head entry present
//            out_ready    - WB consumes the head this cycle
//            out_wr_en    - head enables qualified by out_valid
//            out_wr_addr  - head addresses
//            out_wr_data  - head data
//            stall_cnt    - saturating count of out_valid & ~out_ready cycles
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_pipe_reg #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int NCH           = 2,
  parameter int ZERO_SUPPRESS = 1,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH-1:0]        in_wr_en,
  input  logic [NCH*ADDR_W-1:0] in_wr_addr,
  input  logic [NCH*DATA_W-1:0] in_wr_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH-1:0]        out_wr_en,
  output logic [NCH*ADDR_W-1:0] out_wr_addr,
  output logic [NCH*DATA_W-1:0] out_wr_data,
  output logic [CNT_W-1:0]      stall_cnt
);

  // State encoding is {skid_v, head_v}; 2'b10 is unreachable.
  localparam logic [1:0] c_st_empty = 2'b00;
  localparam logic [1:0] c_st_one   = 2'b01;
  localparam logic [1:0] c_st_full  = 2'b11;

  logic [1:0]            state_q, state_d;
  logic [NCH-1:0]        head_en_q, head_en_d;
  logic [NCH*ADDR_W-1:0] head_addr_q, head_addr_d;
  logic [NCH*DATA_W-1:0] head_data_q, head_data_d;
  logic [NCH-1:0]        skid_en_q, skid_en_d;
  logic [NCH*ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic [NCH*DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic                  w_head_v;
  logic                  w_skid_v;
  logic                  w_acc;
  logic                  w_pop;
  logic [NCH-1:0]        w_cap_en;

  assign w_head_v = state_q[0];
  assign w_skid_v = state_q[1];
  assign w_acc    = in_valid & ~w_skid_v;
  assign w_pop    = w_head_v & out_ready;

  // Capture transform: writes to register 0 are dropped at the input so WB
  // never sees an enable for an address it must ignore.
  generate
    for (genvar i = 0; i < NCH; i++) begin : g_cap
      if (ZERO_SUPPRESS != 0) begin : g_zs
        assign w_cap_en[i] = in_wr_en[i] & (in_wr_addr[i*ADDR_W +: ADDR_W] != '0);
      end else begin : g_pass
        assign w_cap_en[i] = in_wr_en[i];
      end
    end
  endgenerate

  // State register plus entry storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= c_st_empty;
      head_en_q   <= '0;
      head_addr_q <= '0;
      head_data_q <= '0;
      skid_en_q   <= '0;
      skid_addr_q <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      head_en_q   <= head_en_d;
      head_addr_q <= head_addr_d;
      head_data_q <= head_data_d;
      skid_en_q   <= skid_en_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state and datapath loads.
  always_comb begin
    state_d     = state_q;
    head_en_d   = head_en_q;
    head_addr_d = head_addr_q;
    head_data_d = head_data_q;
    skid_en_d   = skid_en_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Flush wins over any same-cycle accept; stored payload is left as-is.
      state_d = c_st_empty;
    end else begin
      case (state_q)
        c_st_empty: begin
          if (w_acc) begin
            state_d     = c_st_one;
            head_en_d   = w_cap_en;
            head_addr_d = in_wr_addr;
            head_data_d = in_wr_data;
          end
        end
        c_st_one: begin
          if (w_acc && w_pop) begin
            head_en_d   = w_cap_en;
            head_addr_d = in_wr_addr;
            head_data_d = in_wr_data;
          end else if (w_acc) begin
            state_d     = c_st_full;
            skid_en_d   = w_cap_en;
            skid_addr_d = in_wr_addr;
            skid_data_d = in_wr_data;
          end else if (w_pop) begin
            state_d = c_st_empty;
          end
        end
        c_st_full: begin
          if (w_pop) begin
            state_d     = c_st_one;
            head_en_d   = skid_en_q;
            head_addr_d = skid_addr_q;
            head_data_d = skid_data_q;
          end
        end
        default: state_d = c_st_empty;
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if (w_head_v && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Outputs.
  always_comb begin
    in_ready    = ~w_skid_v;
    out_valid   = w_head_v;
    out_wr_en   = head_en_q & {NCH{w_head_v}};
    out_wr_addr = head_addr_q;
    out_wr_data = head_data_q;
    stall_cnt   = stall_cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_pipe_reg
// Purpose  : Self-checking bench for mem_wb_pipe_reg. A queue-based model of
//            the elastic register predicts outputs each cycle; a second
//            instance with a 4-bit counter exercises saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_pipe_reg;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NC  = 2;
  localparam int MAXCNT = 65535;

  typedef struct {
    logic [NC-1:0]    en;
    logic [NC*AW-1:0] addr;
    logic [NC*DW-1:0] data;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [NC-1:0]    in_wr_en;
  logic [NC*AW-1:0] in_wr_addr;
  logic [NC*DW-1:0] in_wr_data;
  logic             out_valid;
  logic             out_ready;
  logic [NC-1:0]    out_wr_en;
  logic [NC*AW-1:0] out_wr_addr;
  logic [NC*DW-1:0] out_wr_data;
  logic [15:0]      stall_cnt;

  logic             s_flush;
  logic             s_in_valid;
  logic             s_in_ready;
  logic [NC-1:0]    s_in_wr_en;
  logic [NC*AW-1:0] s_in_wr_addr;
  logic [NC*DW-1:0] s_in_wr_data;
  logic             s_out_valid;
  logic             s_out_ready;
  logic [NC-1:0]    s_out_wr_en;
  logic [NC*AW-1:0] s_out_wr_addr;
  logic [NC*DW-1:0] s_out_wr_data;
  logic [3:0]       s_stall_cnt;

  always #5 clk = ~clk;

  mem_wb_pipe_reg #(.DATA_W(DW), .ADDR_W(AW), .NCH(NC), .ZERO_SUPPRESS(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_wr_data(in_wr_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
    .stall_cnt(stall_cnt)
  );

  mem_wb_pipe_reg #(.DATA_W(DW), .ADDR_W(AW), .NCH(NC), .ZERO_SUPPRESS(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_wr_en(s_in_wr_en), .in_wr_addr(s_in_wr_addr), .in_wr_data(s_in_wr_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_wr_en(s_out_wr_en), .out_wr_addr(s_out_wr_addr), .out_wr_data(s_out_wr_data),
    .stall_cnt(s_stall_cnt)
  );

  int   n_pass  = 0;
  int   n_total = 0;
  ent_t q[$];
  int   m_stall = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic ent_t xform();
    ent_t e;
    e.en   = in_wr_en;
    e.addr = in_wr_addr;
    e.data = in_wr_data;
    for (int i = 0; i < NC; i++)
      if (in_wr_addr[i*AW +: AW] == '0) e.en[i] = 1'b0;
    return e;
  endfunction

  // Model of one clock edge: FIFO of at most two entries.
  task automatic mdl_edge();
    bit acc;
    bit pop;
    acc = in_valid && (q.size() < 2);
    pop = (q.size() > 0) && out_ready;
    if (!rst) begin
      q.delete();
      m_stall = 0;
    end else begin
      if (q.size() > 0 && !out_ready && !flush && m_stall < MAXCNT) m_stall++;
      if (flush) q.delete();
      else begin
        if (pop) q.delete(0);
        if (acc) q.push_back(xform());
      end
    end
  endtask

  task automatic chk_outputs();
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("stall_cnt", stall_cnt, m_stall);
    if (q.size() > 0) begin
      chk("out_wr_en", out_wr_en, q[0].en);
      chk("out_wr_addr", out_wr_addr, q[0].addr);
      chk("out_wr_data", out_wr_data, q[0].data);
    end else begin
      chk("out_wr_en_idle", out_wr_en, 0);
    end
  endtask

  // Inputs set by caller; check at negedge, advance model at posedge.
  task automatic cycle();
    @(negedge clk);
    chk_outputs();
    @(posedge clk);
    mdl_edge();
    #1;
  endtask

  task automatic drive(input bit v, input logic [NC-1:0] en, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    in_valid   = v;
    in_wr_en   = en;
    in_wr_addr = {a1, a0};
    in_wr_data = {d1, d0};
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(0, 2'b00, 0, 0, 0, 0);
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
    s_in_wr_en = 2'b11; s_in_wr_addr = {5'd3, 5'd2}; s_in_wr_data = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_wr_en", out_wr_en, 0);
    chk("rst_addr", out_wr_addr, 0);
    chk("rst_data", out_wr_data, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_sat_stall", s_stall_cnt, 0);
    rst = 1'b1;

    // Streaming at full throughput.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'b11, AW'(i+1), AW'(i+1), 32'hA000_0000 + i, 32'hA000_0000 + i);
      cycle();
    end

    // Back-pressure: three stalled cycles with in_valid held.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b11, AW'(20+i), AW'(21+i), 32'hB000_0000 + i, 32'hB100_0000 + i);
      cycle();
    end
    chk("bp_stall", stall_cnt, 3);
    chk("bp_in_ready", in_ready, 0);
    drive(0, 2'b00, 0, 0, 0, 0);
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("bp_drained_ready", in_ready, 1);

    // Zero suppression on channel 0.
    drive(1, 2'b11, 5'd0, 5'd5, 32'h1111_1111, 32'hDEAD_BEEF);
    cycle();
    chk("zs_en", out_wr_en, 2'b10);
    chk("zs_data1", out_wr_data[DW +: DW], 32'hDEAD_BEEF);
    drive(0, 2'b00, 0, 0, 0, 0);
    cycle();

    // Flush while full with a same-cycle offer.
    out_ready = 1'b0;
    drive(1, 2'b11, 5'd7, 5'd8, 32'hC0DE_0001, 32'hC0DE_0002);
    repeat (2) cycle();
    flush = 1'b1;
    drive(1, 2'b11, 5'd9, 5'd10, 32'hC0DE_0003, 32'hC0DE_0004);
    cycle();
    flush = 1'b0;
    drive(0, 2'b00, 0, 0, 0, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_out_wr_en", out_wr_en, 0);
    chk("fl_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (2) cycle();

    // Asynchronous reset while full.
    out_ready = 1'b0;
    drive(1, 2'b11, 5'd11, 5'd12, 32'hF00D_0001, 32'hF00D_0002);
    repeat (3) cycle();
    chk("pre_ar_full", in_ready, 0);
    #2 rst = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_wr_en", out_wr_en, 0);
    chk("ar_addr", out_wr_addr, 0);
    chk("ar_data", out_wr_data, 0);
    chk("ar_stall", stall_cnt, 0);
    chk("ar_in_ready", in_ready, 1);
    q.delete();
    m_stall = 0;
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1, 2'b01, 5'd13, 5'd14, 32'h0000_0013, 32'h0000_0014);
    repeat (3) cycle();

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      a0 = ($urandom % 4 == 0) ? '0 : AW'($urandom_range(1, 31));
      a1 = ($urandom % 4 == 0) ? '0 : AW'($urandom_range(1, 31));
      drive(($urandom % 4) != 0, NC'($urandom), a0, a1, $urandom, $urandom);
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 16) == 0;
      cycle();
    end
    flush = 1'b0;
    drive(0, 2'b00, 0, 0, 0, 0);

    // Saturation of a 4-bit counter.
    s_in_valid = 1'b1;
    cycle();
    s_in_valid  = 1'b0;
    s_out_ready = 1'b0;
    repeat (14) cycle();
    chk("sat_count14", s_stall_cnt, 14);
    repeat (6) cycle();
    chk("sat_count20", s_stall_cnt, 15);
    repeat (5) cycle();
    chk("sat_hold", s_stall_cnt, 15);
    chk("sat_valid", s_out_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
